// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_regfile_pkg
// Brief  : Shared pipeline encodings for the write-back stage. The decoder /
//          control unit drives resultsrc and loadsrc with these same values.
//          No ports (package).
// Rev    : 1.0  initial release
// ============================================================================
package wb_regfile_pkg;

  typedef logic [31:0] word_t;

  // Write-back result select (resultsrc). Unlisted codes fall back to ALU.
  localparam logic [2:0] C_RES_ALU    = 3'b000;
  localparam logic [2:0] C_RES_LOAD   = 3'b001;
  localparam logic [2:0] C_RES_PCPLUS4 = 3'b010;
  localparam logic [2:0] C_RES_IMM    = 3'b011;
  localparam logic [2:0] C_RES_AUIPC  = 3'b100;

  // Load type (loadsrc). Unlisted codes behave as a full-word load.
  localparam logic [2:0] C_LD_LW  = 3'b000;
  localparam logic [2:0] C_LD_LH  = 3'b001;
  localparam logic [2:0] C_LD_LB  = 3'b010;
  localparam logic [2:0] C_LD_LHU = 3'b011;
  localparam logic [2:0] C_LD_LBU = 3'b100;

  localparam int C_NUM_REGS = 32;

endpackage : wb_regfile_pkg
`default_nettype wire

// File: rtl/wb_load_ext.sv
`default_nettype none
// ============================================================================
// Module : wb_load_ext
// Brief  : Combinational load-data extraction and sign/zero extension.
// Ports  : readDataW [31:0] in  - raw word returned by data memory
//          offset    [1:0]  in  - byte offset of the access within the word
//          loadsrcW  [2:0]  in  - load type (lw/lh/lb/lhu/lbu)
//          data      [31:0] out - extended load value
// Rev    : 1.0  initial release
// ============================================================================
module wb_load_ext
  import wb_regfile_pkg::*;
(
  input  logic [31:0] readDataW,
  input  logic [1:0]  offset,
  input  logic [2:0]  loadsrcW,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = readDataW[7:0];
    case (offset)
      2'd0: w_byte = readDataW[7:0];
      2'd1: w_byte = readDataW[15:8];
      2'd2: w_byte = readDataW[23:16];
      2'd3: w_byte = readDataW[31:24];
      default: w_byte = readDataW[7:0];
    endcase

    // Halfword selection ignores offset[0]; misaligned halfwords are not
    // the concern of this stage.
    w_half = offset[1] ? readDataW[31:16] : readDataW[15:0];

    data = readDataW;
    case (loadsrcW)
      C_LD_LH:  data = {{16{w_half[15]}}, w_half};
      C_LD_LHU: data = {16'h0000, w_half};
      C_LD_LB:  data = {{24{w_byte[7]}}, w_byte};
      C_LD_LBU: data = {24'h000000, w_byte};
      default:  data = readDataW;
    endcase
  end

endmodule : wb_load_ext
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module : wb_regfile
// Brief  : Write-back result mux plus 32x32 register file with write-first
//          bypass to both decode read ports.
// Ports  : clk, rst                 - clock, synchronous active-high reset
//          regwriteW, rdW           - write enable and destination index
//          aluresultW, readDataW,
//          auipcW, immextW, pcplus4W - write-back candidates
//          resultsrcW, loadsrcW      - result select and load type
//          rs1D, rs2D / rd1D, rd2D   - decode read indices / read data
//          resultW                   - selected write-back value
// Rev    : 1.0  initial release
// ============================================================================
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        regwriteW,
  input  logic [4:0]  rdW,
  input  logic [31:0] aluresultW,
  input  logic [31:0] readDataW,
  input  logic [31:0] auipcW,
  input  logic [31:0] immextW,
  input  logic [31:0] pcplus4W,
  input  logic [2:0]  resultsrcW,
  input  logic [2:0]  loadsrcW,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  output logic [31:0] rd1D,
  output logic [31:0] rd2D,
  output logic [31:0] resultW
);

  word_t r_regs [C_NUM_REGS];
  word_t w_load_data;
  logic  w_write;

  wb_load_ext u_load_ext (
    .readDataW (readDataW),
    .offset    (aluresultW[1:0]),
    .loadsrcW  (loadsrcW),
    .data      (w_load_data)
  );

  always_comb begin
    resultW = aluresultW;
    case (resultsrcW)
      C_RES_LOAD:    resultW = w_load_data;
      C_RES_PCPLUS4: resultW = pcplus4W;
      C_RES_IMM:     resultW = immextW;
      C_RES_AUIPC:   resultW = auipcW;
      default:       resultW = aluresultW;
    endcase
  end

  // A write is effective only outside reset and never to x0; the same term
  // gates the bypass so reset also suppresses forwarding.
  assign w_write = regwriteW && (rdW != 5'd0) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_write) begin
      r_regs[rdW] <= resultW;
    end
  end

  // Entry 0 is never written but is still masked on read so x0 is a hard zero
  // even before the first reset.
  always_comb begin
    rd1D = '0;
    if (w_write && (rs1D == rdW)) begin
      rd1D = resultW;
    end else if (rs1D != 5'd0) begin
      rd1D = r_regs[rs1D];
    end
  end

  always_comb begin
    rd2D = '0;
    if (w_write && (rs2D == rdW)) begin
      rd2D = resultW;
    end else if (rs2D != 5'd0) begin
      rd2D = r_regs[rs2D];
    end
  end

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_regfile
// Brief  : Self-checking bench for wb_regfile: directed scenarios followed by
//          randomized traffic compared against a behavioural model.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        regwriteW;
  logic [4:0]  rdW;
  logic [31:0] aluresultW;
  logic [31:0] readDataW;
  logic [31:0] auipcW;
  logic [31:0] immextW;
  logic [31:0] pcplus4W;
  logic [2:0]  resultsrcW;
  logic [2:0]  loadsrcW;
  logic [4:0]  rs1D;
  logic [4:0]  rs2D;
  logic [31:0] rd1D;
  logic [31:0] rd2D;
  logic [31:0] resultW;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [32];

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .regwriteW  (regwriteW),
    .rdW        (rdW),
    .aluresultW (aluresultW),
    .readDataW  (readDataW),
    .auipcW     (auipcW),
    .immextW    (immextW),
    .pcplus4W   (pcplus4W),
    .resultsrcW (resultsrcW),
    .loadsrcW   (loadsrcW),
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .rd1D       (rd1D),
    .rd2D       (rd2D),
    .resultW    (resultW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Load value from the architectural rules: shift the addressed lane down,
  // then extend by the width and signedness of the access.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input int off, input int ls);
    logic [31:0] sh;
    logic [15:0] h;
    logic [7:0]  b;
    sh = word >> (8 * off);
    b  = sh[7:0];
    sh = word >> (16 * (off / 2));
    h  = sh[15:0];
    case (ls)
      1: return {{16{h[15]}}, h};
      3: return {16'h0, h};
      2: return {{24{b[7]}}, b};
      4: return {24'h0, b};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] ref_result();
    case (int'(resultsrcW))
      1: return ref_load(readDataW, int'(aluresultW[1:0]), int'(loadsrcW));
      2: return pcplus4W;
      3: return immextW;
      4: return auipcW;
      default: return aluresultW;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] rs);
    if (!rst && regwriteW && rdW != 0 && rs == rdW) return ref_result();
    if (rs == 0) return 32'h0;
    return model[rs];
  endfunction

  // Check all outputs mid-cycle, then advance one clock and update the model.
  task automatic cycle(input string tag);
    @(negedge clk);
    check({tag, ".result"}, resultW, ref_result());
    check({tag, ".rd1"}, rd1D, ref_read(rs1D));
    check({tag, ".rd2"}, rd2D, ref_read(rs2D));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (regwriteW && rdW != 0) begin
      model[rdW] = ref_result();
    end
    #1;
  endtask

  task automatic set_idle();
    regwriteW = 0; rdW = 0; resultsrcW = 0; loadsrcW = 0;
    aluresultW = 0; readDataW = 0; auipcW = 0; immextW = 0; pcplus4W = 0;
    rs1D = 0; rs2D = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] ld_exp [5];
  int          ld_src [5];
  int          ld_off [5];

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    set_idle();
    rst = 1;
    #1;

    // Reset, then read array contents with bypass disabled.
    cycle("rst0");
    rs1D = 5; rs2D = 31;
    @(negedge clk);
    check("rst_rd1", rd1D, 32'h0);
    check("rst_rd2", rd2D, 32'h0);
    @(posedge clk); #1;

    // Write x5 with same-cycle visibility, then from the array.
    rst = 0; regwriteW = 1; rdW = 5; resultsrcW = 3'b000;
    aluresultW = 32'h12345678; rs1D = 5;
    @(negedge clk);
    check("x5_bypass", rd1D, 32'h12345678);
    @(posedge clk); model[5] = 32'h12345678; #1;
    regwriteW = 0; aluresultW = 0;
    @(negedge clk);
    check("x5_array", rd1D, 32'h12345678);
    @(posedge clk); #1;

    // Load extension table.
    resultsrcW = 3'b001; readDataW = 32'h80F7A5C3;
    ld_src[0] = 2; ld_off[0] = 0; ld_exp[0] = 32'hFFFFFFC3;
    ld_src[1] = 4; ld_off[1] = 2; ld_exp[1] = 32'h000000F7;
    ld_src[2] = 1; ld_off[2] = 2; ld_exp[2] = 32'hFFFF80F7;
    ld_src[3] = 3; ld_off[3] = 0; ld_exp[3] = 32'h0000A5C3;
    ld_src[4] = 0; ld_off[4] = 1; ld_exp[4] = 32'h80F7A5C3;
    for (int i = 0; i < 5; i++) begin
      loadsrcW = 3'(ld_src[i]);
      aluresultW = 32'h1000 + 32'(ld_off[i]);
      #1;
      check($sformatf("load%0d", i), resultW, ld_exp[i]);
    end
    loadsrcW = 3'b110; aluresultW = 32'h1003; #1;
    check("load_rsvd_lw", resultW, 32'h80F7A5C3);

    // Result mux.
    pcplus4W = 32'h104; immextW = 32'hABCDE000; auipcW = 32'h2000;
    aluresultW = 32'h0BAD_F00D;
    resultsrcW = 3'b010; #1; check("mux_pc4", resultW, 32'h104);
    resultsrcW = 3'b011; #1; check("mux_imm", resultW, 32'hABCDE000);
    resultsrcW = 3'b100; #1; check("mux_auipc", resultW, 32'h2000);
    resultsrcW = 3'b111; #1; check("mux_rsvd", resultW, 32'h0BADF00D);
    @(posedge clk); #1;

    // Write to x0 is ignored.
    resultsrcW = 0; aluresultW = 32'hDEADBEEF; regwriteW = 1; rdW = 0;
    rs1D = 0; rs2D = 0;
    @(negedge clk);
    check("x0_rd1", rd1D, 32'h0);
    check("x0_rd2", rd2D, 32'h0);
    @(posedge clk); #1;
    regwriteW = 0; rs1D = 5;
    #1; check("x0_nochange_x5", rd1D, 32'h12345678);

    // Fill x1..x31, then reset concurrent with a write to x7.
    for (int i = 1; i < 32; i++) begin
      regwriteW = 1; rdW = 5'(i); resultsrcW = 0;
      aluresultW = 32'h0101_0101 * 32'(i) + 32'h10;
      rs1D = 5'(i); rs2D = 5'(32 - i);
      cycle("fill");
    end
    regwriteW = 1; rdW = 7; aluresultW = 32'hCAFE0007; rst = 1;
    rs1D = 7; rs2D = 8;
    @(negedge clk);
    check("rst_nobypass", rd1D, model[7]);
    @(posedge clk);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    rst = 0; regwriteW = 0;
    for (int i = 0; i < 32; i++) begin
      rs1D = 5'(i); rs2D = 5'(31 - i);
      #1;
      check($sformatf("post_rst_x%0d", i), rd1D, 32'h0);
    end

    // Dual-port bypass on the same register.
    regwriteW = 1; rdW = 9; aluresultW = 32'h1111; cycle("x9_init");
    rs1D = 9; rs2D = 9; regwriteW = 1; aluresultW = 32'h55;
    #1;
    check("dual_byp1", rd1D, 32'h55);
    check("dual_byp2", rd2D, 32'h55);
    regwriteW = 0; #1;
    check("dual_old1", rd1D, 32'h1111);
    check("dual_old2", rd2D, 32'h1111);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 39) == 0);
      regwriteW  = 1'($urandom_range(0, 3) != 0);
      rdW        = 5'($urandom);
      rs1D       = ($urandom_range(0, 2) == 0) ? rdW : 5'($urandom);
      rs2D       = ($urandom_range(0, 2) == 0) ? rdW : 5'($urandom);
      resultsrcW = 3'($urandom);
      loadsrcW   = 3'($urandom);
      aluresultW = $urandom;
      readDataW  = $urandom;
      auipcW     = $urandom;
      immextW    = $urandom;
      pcplus4W   = $urandom;
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wb_regfile
`default_nettype wire

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL expose: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL expose: regwriteW  input  1  write-back enable from the MEM/WB register.
REQ-004 SHALL expose: rdW  input  5  destination register index.
REQ-005 SHALL expose: aluresultW, readDataW, auipcW, immextW, pcplus4W  input  32 each  write-back candidates.
REQ-006 SHALL expose: resultsrcW  input  3  result select; loadsrcW  input  3  load type.
REQ-007 SHALL expose: rs1D, rs2D  input  5 each  decode-stage read indices.
REQ-008 SHALL expose: rd1D, rd2D  output  32 each  decode-stage read data.
REQ-009 SHALL expose: resultW  output  32  final write-back value, also fed to the hazard/forwarding unit.
REQ-010 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-011 resultW SHALL be combinational: resultsrcW 000 -> aluresultW; 001 -> extended load data; 010 -> pcplus4W; 011 -> immextW; 100 -> auipcW; 101-111 -> aluresultW.
REQ-012 Load extension SHALL use byte offset aluresultW[1:0] into readDataW.
REQ-013 loadsrcW 000 (lw) -> readDataW unchanged.
REQ-014 loadsrcW 001 (lh) -> halfword at aluresultW[1] (0: bits 15:0, 1: bits 31:16), sign-extended; 011 (lhu) -> same halfword, zero-extended.
REQ-015 loadsrcW 010 (lb) -> byte at offset, sign-extended; 100 (lbu) -> byte at offset, zero-extended.
REQ-016 loadsrcW 101-111 SHALL be treated as lw.
REQ-017 The register file SHALL hold 32 registers of 32 bits each; x0 SHALL always read 0 and SHALL never be written.
REQ-018 On the rising clk edge with rst=0, regwriteW=1 and rdW!=0, register[rdW] SHALL load resultW; otherwise no register SHALL change.
REQ-019 Reads SHALL be combinational: rdND = 0 if rsND=0, else register[rsND].
REQ-020 Write-first bypass: if regwriteW=1, rdW!=0, rst=0 and rsND==rdW, rdND SHALL equal the current resultW, giving same-cycle write/read visibility with zero added latency.
REQ-021 Both read ports SHALL bypass independently; rs1D==rs2D==rdW SHALL return resultW on both ports.
REQ-022 Write latency SHALL be one cycle (value visible from the array on the next cycle, and in the same cycle via bypass).

Reset
REQ-023 With rst=1 at a clk edge, all 31 writable registers SHALL clear to 0; any concurrent write SHALL be dropped.
REQ-024 While rst=1, bypass SHALL be disabled and rd1D/rd2D SHALL read the array contents (0 after the first reset edge).
REQ-025 resultW SHALL have no reset value of its own; it follows its inputs at all times.
REQ-026 Deasserting rst mid-stream SHALL allow a write on the first edge with rst=0.

Structure
REQ-027 The resultsrc and loadsrc encodings SHALL be defined as named constants in the shared pipeline package, which the decoder/control unit also uses.
REQ-028 Load extension SHALL be a separate combinational sub-module, wb_load_ext (inputs readDataW, offset, loadsrcW; output 32-bit data).
REQ-029 The register array, write logic and bypass SHALL live in wb_regfile.

Verification
REQ-030 Reset, then write x5=0x12345678 (resultsrc 000) -> same-cycle rd1D(rs1D=5)=0x12345678; next cycle still 0x12345678 with regwriteW=0.
REQ-031 readDataW=0x80F7A5C3, resultsrc 001: lb offset 0 -> 0xFFFFFFC3; lbu offset 2 -> 0x000000F7; lh offset 2 -> 0xFFFF80F7; lhu offset 0 -> 0x0000A5C3; lw -> 0x80F7A5C3.
REQ-032 Write rdW=0 with resultW=0xDEADBEEF -> rs1D=0 and rs2D=0 read 0, and no register changes.
REQ-033 resultsrc 010/011/100 with pcplus4W=0x104, immextW=0xABCDE000, auipcW=0x2000 -> resultW equals 0x104, 0xABCDE000, 0x2000 respectively; resultsrc 111 -> aluresultW.
REQ-034 Fill x1..x31 with nonzero values, then assert rst together with a write to x7 -> all reads return 0 afterwards and x7 is not written.
REQ-035 rs1D=rs2D=rdW=9, regwriteW=1, resultW=0x55 -> rd1D=rd2D=0x55 in the same cycle; with regwriteW=0 both ports return the old x9.
